// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters and branch statistics.
// Ports:
//   clk, rst (async active-low)
//   fetch_pc -> pred_taken, pred_target (same-cycle lookup)
//   upd_* : one decode-stage resolution per cycle; mispredict is combinational
//   inv : clear all valid bits; branch_cnt / mispred_cnt : saturating stats
module branch_predictor_btb #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 32,
    parameter int PRED_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    input  logic             inv,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] u_tag;
    logic             f_hit;
    logic             u_hit;
    logic [1:0]       u_ctr;

    // Byte offset and bits above the tag do not take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc, upd_pc};

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+1+TAG_W:IDX_W+2];

    // Lookup reads registered state only: a same-cycle update is not bypassed.
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    assign pred_taken  = (PRED_MODE == 1) && f_hit && ctr_q[f_idx][1];
    assign pred_target = f_hit ? tgt_q[f_idx] : '0;

    assign mispredict = upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (upd_valid) begin
                if (u_hit) begin
                    if (upd_taken) begin
                        ctr_q[u_idx] <= (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
                        tgt_q[u_idx] <= upd_target;
                    end else begin
                        ctr_q[u_idx] <= (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
                    end
                end else if (upd_taken) begin
                    // Allocate over whatever occupies the slot, weakly taken.
                    valid_q[u_idx] <= 1'b1;
                    tag_q[u_idx]   <= u_tag;
                    tgt_q[u_idx]   <= upd_target;
                    ctr_q[u_idx]   <= 2'b10;
                end
            end
            // Later assignment wins: invalidate overrides a same-cycle allocate.
            if (inv) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid && !(&branch_cnt)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (mispredict && !(&mispred_cnt)) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end

endmodule
